// File: rtl/rx_descrambler_32_if.sv
// Symbol-word bus into and out of the 32-bit RX descrambler.
interface rx_descrambler_32_if;
  logic [31:0] rx_data_in;
  logic [3:0]  rx_datak_in;
  logic        rx_valid_in;
  logic        scramble_disable;
  logic [31:0] rx_data_out;
  logic [3:0]  rx_datak_out;
  logic        rx_valid_out;
  logic        ts_active;
  logic        com_misalign;

  modport master (
    output rx_data_in, rx_datak_in, rx_valid_in, scramble_disable,
    input  rx_data_out, rx_datak_out, rx_valid_out, ts_active, com_misalign
  );
  modport slave (
    input  rx_data_in, rx_datak_in, rx_valid_in, scramble_disable,
    output rx_data_out, rx_datak_out, rx_valid_out, ts_active, com_misalign
  );
endinterface

// File: rtl/rx_descrambler_32.sv
// Gen1/Gen2 RX descrambler, 4 symbols per pclk. One word of lookahead lets
// TS1/TS2 be recognised from the COM word itself (TS id sits in symbol 6).
module rx_descrambler_32 #(
  parameter logic [15:0] LFSR_SEED = 16'hFFFF,
  parameter logic [7:0]  COM_SYM   = 8'hBC,
  parameter logic [7:0]  SKP_SYM   = 8'h1C,
  parameter logic [7:0]  TS1_ID    = 8'h4A,
  parameter logic [7:0]  TS2_ID    = 8'h45
) (
  input  logic               pclk,
  input  logic               reset_n,
  rx_descrambler_32_if.slave bus
);

  logic [15:0]     lfsr, lfsr_v;
  logic [3:0][7:0] hold_data, proc;
  logic [3:0]      hold_k;
  logic            hold_valid;
  logic [1:0]      ts_cnt, ts_cnt_nxt;
  logic [7:0]      key, la2;
  logic            com0, ts_start, ts_cont, mis;

  // Galois form: key bit is taken from bit 15 before each shift
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:5], l[4] ^ l[15], l[3] ^ l[15], l[2] ^ l[15], l[1:0], l[15]};
  endfunction

  always_comb begin
    com0     = hold_k[0] && (hold_data[0] == COM_SYM);
    la2      = bus.rx_data_in[23:16];
    ts_start = com0 && !bus.rx_datak_in[2] && (la2 == TS1_ID || la2 == TS2_ID);
    // a COM on byte 0 ends any TS in flight and is judged afresh
    ts_cont  = (ts_cnt != 2'd0) && !com0;
    ts_cnt_nxt = ts_start ? 2'd3 : (ts_cont ? ts_cnt - 2'd1 : 2'd0);
    lfsr_v = lfsr;
    proc   = hold_data;
    mis    = 1'b0;
    key    = '0;
    for (int b = 0; b < 4; b++) begin
      if (hold_k[b] && hold_data[b] == COM_SYM) begin
        lfsr_v = LFSR_SEED;
        if (b != 0) mis = 1'b1;
      end else if (!(hold_k[b] && hold_data[b] == SKP_SYM)) begin
        for (int i = 0; i < 8; i++) begin
          key[i] = lfsr_v[15];
          lfsr_v = lfsr_step(lfsr_v);
        end
        if (!hold_k[b] && !(bus.scramble_disable || ts_cont || (ts_start && b != 0)))
          proc[b] = hold_data[b] ^ key;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr             <= LFSR_SEED;
      hold_data        <= '0;
      hold_k           <= '0;
      hold_valid       <= 1'b0;
      ts_cnt           <= 2'd0;
      bus.rx_data_out  <= '0;
      bus.rx_datak_out <= '0;
      bus.rx_valid_out <= 1'b0;
      bus.ts_active    <= 1'b0;
      bus.com_misalign <= 1'b0;
    end else begin
      bus.rx_valid_out <= 1'b0;
      bus.ts_active    <= 1'b0;
      bus.com_misalign <= 1'b0;
      if (bus.rx_valid_in) begin
        hold_data  <= bus.rx_data_in;
        hold_k     <= bus.rx_datak_in;
        hold_valid <= 1'b1;
        if (hold_valid) begin
          lfsr             <= lfsr_v;
          ts_cnt           <= ts_cnt_nxt;
          bus.rx_data_out  <= proc;
          bus.rx_datak_out <= hold_k;
          bus.rx_valid_out <= 1'b1;
          bus.ts_active    <= ts_start || ts_cont;
          bus.com_misalign <= mis;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_descrambler_32.sv
// Vector table plus scoreboard for rx_descrambler_32; keys come from a
// byte-offset-since-COM table generated from the serial LFSR.
module tb_rx_descrambler_32;
  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  rx_descrambler_32_if bus();

  rx_descrambler_32 dut (.pclk(pclk), .reset_n(reset_n), .bus(bus));

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        sd;
    logic        ue;
    logic [31:0] ed;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        ts;
    logic        mis;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [7:0] keytab [256];
  vec_t tbl [18];

  // model state: held word and byte offset since last COM
  logic        m_hv = 1'b0;
  logic [31:0] m_hd, m_hed;
  logic [3:0]  m_hk;
  logic        m_hsd, m_hue;
  int          m_n = 0;
  int          m_ts = 0;

  function automatic logic [31:0] w(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic model(input logic [31:0] d, input logic [3:0] k,
                       input logic [31:0] ld, input logic [3:0] lk,
                       input logic sd, output exp_t e);
    logic com0, start, cont;
    logic [7:0] s;
    com0  = k[0] && d[7:0] == 8'hBC;
    start = com0 && !lk[2] && (ld[23:16] == 8'h4A || ld[23:16] == 8'h45);
    cont  = (m_ts != 0) && !com0;
    e.d = d; e.k = k; e.ts = start || cont; e.mis = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s = d[8*b +: 8];
      if (k[b] && s == 8'hBC) begin
        m_n = 0;
        if (b != 0) e.mis = 1'b1;
      end else if (!(k[b] && s == 8'h1C)) begin
        if (!k[b] && !(sd || cont || (start && b != 0)))
          e.d[8*b +: 8] = s ^ keytab[m_n & 255];
        m_n++;
      end
    end
    m_ts = start ? 3 : (cont ? m_ts - 1 : 0);
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic sd,
                      input logic ue, input logic [31:0] ed);
    exp_t e;
    if (m_hv) begin
      model(m_hd, m_hk, d, k, m_hsd, e);
      if (m_hue) e.d = m_hed;
      sb.push_back(e);
    end
    @(negedge pclk);
    bus.rx_data_in       = d;
    bus.rx_datak_in      = k;
    bus.rx_valid_in      = 1'b1;
    bus.scramble_disable = m_hv ? m_hsd : 1'b0;
    m_hd = d; m_hk = k; m_hsd = sd; m_hue = ue; m_hed = ed; m_hv = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      bus.rx_valid_in      = 1'b0;
      bus.rx_data_in       = $urandom;
      bus.rx_datak_in      = 4'($urandom);
      bus.scramble_disable = 1'($urandom);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge pclk) begin
    #2;
    if (reset_n) begin
      if (bus.rx_valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data", bus.rx_data_out, e.d);
          chk("datak", {28'd0, bus.rx_datak_out}, {28'd0, e.k});
          chk("ts_active", {31'd0, bus.ts_active}, {31'd0, e.ts});
          chk("com_misalign", {31'd0, bus.com_misalign}, {31'd0, e.mis});
        end
      end else begin
        chk("idle_flags", {30'd0, bus.ts_active, bus.com_misalign}, 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l;
    l = 16'hFFFF;
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 8; i++) begin
        keytab[n][i] = l[15];
        l = {l[14:5], l[4] ^ l[15], l[3] ^ l[15], l[2] ^ l[15], l[1:0], l[15]};
      end
    end

    tbl[0]  = '{w(8'hBC,8'h00,8'h00,8'h00), 4'b0001, 1'b0, 1'b1, w(8'hBC,8'hFF,8'h17,8'hC0)};
    tbl[1]  = '{32'h0, 4'b0000, 1'b0, 1'b1, w(8'h14,8'hB2,8'hE7,8'h02)};
    tbl[2]  = '{w(8'h11,8'h22,8'h33,8'h44), 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{w(8'hBC,8'h1C,8'h1C,8'h1C), 4'b1111, 1'b0, 1'b1, w(8'hBC,8'h1C,8'h1C,8'h1C)};
    tbl[4]  = '{32'h0, 4'b0000, 1'b0, 1'b1, w(8'hFF,8'h17,8'hC0,8'h14)};
    tbl[5]  = '{w(8'hA5,8'h5A,8'h3C,8'hC3), 4'b0000, 1'b1, 1'b1, w(8'hA5,8'h5A,8'h3C,8'hC3)};
    tbl[6]  = '{32'h0, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{w(8'hBC,8'h01,8'h02,8'h03), 4'b0001, 1'b0, 1'b1, w(8'hBC,8'h01,8'h02,8'h03)};
    tbl[8]  = '{w(8'h04,8'h05,8'h4A,8'h4A), 4'b0000, 1'b0, 1'b1, w(8'h04,8'h05,8'h4A,8'h4A)};
    tbl[9]  = '{32'h4A4A4A4A, 4'b0000, 1'b0, 1'b1, 32'h4A4A4A4A};
    tbl[10] = '{32'h4A4A4A4A, 4'b0000, 1'b0, 1'b1, 32'h4A4A4A4A};
    tbl[11] = '{32'h0, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{w(8'hBC,8'h01,8'h02,8'h03), 4'b0001, 1'b0, 1'b1, w(8'hBC,8'h01,8'h02,8'h03)};
    tbl[13] = '{w(8'h04,8'h05,8'h45,8'h45), 4'b0000, 1'b0, 1'b1, w(8'h04,8'h05,8'h45,8'h45)};
    tbl[14] = '{w(8'hBC,8'h00,8'h00,8'h00), 4'b0001, 1'b0, 1'b1, w(8'hBC,8'hFF,8'h17,8'hC0)};
    tbl[15] = '{w(8'h00,8'h00,8'hBC,8'h00), 4'b0100, 1'b0, 1'b1, w(8'h14,8'hB2,8'hBC,8'hFF)};
    tbl[16] = '{32'h0, 4'b0000, 1'b0, 1'b1, w(8'h17,8'hC0,8'h14,8'hB2)};
    tbl[17] = '{w(8'hDE,8'hAD,8'hBE,8'hEF), 4'b0000, 1'b0, 1'b0, 32'h0};

    bus.rx_data_in = 32'h0;
    bus.rx_datak_in = 4'h0;
    bus.rx_valid_in = 1'b0;
    bus.scramble_disable = 1'b0;

    // reset state
    repeat (3) @(negedge pclk);
    chk("rst_data", bus.rx_data_out, 32'h0);
    chk("rst_datak", {28'd0, bus.rx_datak_out}, 32'h0);
    chk("rst_valid", {31'd0, bus.rx_valid_out}, 32'h0);
    chk("rst_ts", {31'd0, bus.ts_active}, 32'h0);
    chk("rst_mis", {31'd0, bus.com_misalign}, 32'h0);
    reset_n = 1'b1;
    idle(3);

    // first word alone produces nothing; bubble before the second
    send(tbl[0].d, tbl[0].k, tbl[0].sd, tbl[0].ue, tbl[0].ed);
    idle(3);
    chk("first_word_pending", sb.size(), 32'd0);
    for (int i = 1; i < 18; i++)
      send(tbl[i].d, tbl[i].k, tbl[i].sd, tbl[i].ue, tbl[i].ed);

    // random data with bubbles and scramble_disable toggling
    for (int i = 0; i < 24; i++) begin
      send($urandom, 4'h0, 1'($urandom_range(0, 3) == 0), 1'b0, 32'h0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    chk("sb_drained_pre_reset", sb.size(), 32'd0);

    // mid-stream reset clears outputs at once
    @(negedge pclk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data", bus.rx_data_out, 32'h0);
    chk("mid_rst_datak", {28'd0, bus.rx_datak_out}, 32'h0);
    m_hv = 1'b0; m_n = 0; m_ts = 0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    send(w(8'hBC,8'h00,8'h00,8'h00), 4'b0001, 1'b0, 1'b1, w(8'hBC,8'hFF,8'h17,8'hC0));
    send(32'h0, 4'b0000, 1'b0, 1'b1, w(8'h14,8'hB2,8'hE7,8'h02));
    send(32'h0, 4'b0000, 1'b0, 1'b0, 32'h0);
    idle(4);
    chk("sb_drained_end", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
